// File: rtl/red_pkg.sv
// Shared types and constants for the byte-serial RED responder.
// Holds the FSM state encoding, the lane count and the accumulator width.
package red_pkg;

    localparam int RED_LANES  = 4;
    localparam int RED_LANE_W = 8;
    localparam int RED_ACC_W  = RED_LANE_W + 2;

    typedef logic [1:0] red_lane_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } red_state_t;

endpackage

// File: rtl/red_lane_mux.sv
// Combinational 4:1 byte selector for the RED responder.
// Lane order is In1 low, In2 low, In1 high, In2 high; the chosen byte is
// zero-extended to the accumulator width so the adder sees unsigned data.
module red_lane_mux
    import red_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 8,
    parameter int ACC_W  = LANE_W + 2
) (
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  red_lane_t        lane,
    output logic [ACC_W-1:0] lane_val
);

    logic [LANE_W-1:0] lane_byte;

    // Pick the operand byte for the current lane
    always_comb begin
        lane_byte = '0;
        case (lane)
            2'd0:    lane_byte = op_a[LANE_W-1:0];
            2'd1:    lane_byte = op_b[LANE_W-1:0];
            2'd2:    lane_byte = op_a[2*LANE_W-1:LANE_W];
            default: lane_byte = op_b[2*LANE_W-1:LANE_W];
        endcase
    end

    assign lane_val = {{(ACC_W-LANE_W){1'b0}}, lane_byte};

endmodule

// File: rtl/red_seq.sv
// Byte-serial RED responder: sums the four operand bytes one per cycle and
// pulses done with the sign-extended 10-bit sum (bit 9 acts as the sign).
// Optional feature: define RED_SEQ_FLUSH_EN to add a flush input that
// abandons an operation in ACC or DONE and returns to IDLE.
module red_seq
    import red_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int LANE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef RED_SEQ_FLUSH_EN
    input  logic             flush,
`endif
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum
);

    localparam int ACC_W = LANE_W + 2;
    localparam red_lane_t LAST_LANE = red_lane_t'(RED_LANES - 1);

    red_state_t        state_q, state_d;
    red_lane_t         lane_q, lane_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WIDTH-1:0]  op_a_q, op_a_d;
    logic [WIDTH-1:0]  op_b_q, op_b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;

    logic [ACC_W-1:0]  lane_val;
    logic [ACC_W-1:0]  acc_next;
    logic              last_lane;
    logic              flush_hit;
    logic              accept;

    red_lane_mux #(
        .WIDTH  (WIDTH),
        .LANE_W (LANE_W),
        .ACC_W  (ACC_W)
    ) u_lane_mux (
        .op_a     (op_a_q),
        .op_b     (op_b_q),
        .lane     (lane_q),
        .lane_val (lane_val)
    );

    assign acc_next  = acc_q + lane_val;
    assign last_lane = (lane_q == LAST_LANE);

    // Decide whether this edge flushes or accepts a new request; flush wins over start
    always_comb begin
        flush_hit = 1'b0;
`ifdef RED_SEQ_FLUSH_EN
        flush_hit = flush && (state_q != IDLE);
`endif
        accept = start && !flush_hit && ((state_q == IDLE) || (state_q == DONE));
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: four ACC cycles, then one DONE cycle that may chain into a new op
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ACC;
            end
            ACC: begin
                if (flush_hit)      state_d = IDLE;
                else if (last_lane) state_d = DONE;
            end
            DONE: begin
                if (accept) state_d = ACC;
                else        state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch operands on accept, add one lane per ACC cycle, load Sum on the last lane
    always_comb begin
        lane_d = lane_q;
        acc_d  = acc_q;
        op_a_d = op_a_q;
        op_b_d = op_b_q;
        sum_d  = sum_q;
        if (accept) begin
            op_a_d = In1;
            op_b_d = In2;
            acc_d  = '0;
            lane_d = '0;
        end else if (flush_hit) begin
            acc_d  = '0;
            lane_d = '0;
        end else if (state_q == ACC) begin
            acc_d  = acc_next;
            lane_d = lane_q + 2'd1;
            if (last_lane) begin
                sum_d = {{(WIDTH-ACC_W){acc_next[ACC_W-1]}}, acc_next};
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
            acc_q  <= '0;
            op_a_q <= '0;
            op_b_q <= '0;
            sum_q  <= '0;
        end else begin
            lane_q <= lane_d;
            acc_q  <= acc_d;
            op_a_q <= op_a_d;
            op_b_q <= op_b_d;
            sum_q  <= sum_d;
        end
    end

    // Outputs decoded from the current state
    always_comb begin
        busy = (state_q == ACC);
        done = (state_q == DONE);
        Sum  = sum_q;
    end

endmodule

// File: tb/tb_red_seq.sv
// Self-checking bench for red_seq: a table of single operations with
// hand-computed sums, followed by back-to-back, reset and flush sequences.
module tb_red_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        flush;
    logic [15:0] in1;
    logic [15:0] in2;
    logic        busy;
    logic        done;
    logic [15:0] sum;

    int vec_count;
    int err_count;

    typedef struct {
        logic [15:0] in1;
        logic [15:0] in2;
        logic [15:0] exp_sum;
    } vec_t;

    vec_t vecs[6];

    red_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
`ifdef RED_SEQ_FLUSH_EN
        .flush (flush),
`endif
        .In1   (in1),
        .In2   (in2),
        .busy  (busy),
        .done  (done),
        .Sum   (sum)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Present a request for exactly one cycle; returns in cycle c+1 with operands scrambled
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(negedge clk);
        start = 1'b0;
        in1   = 16'($urandom);
        in2   = 16'($urandom);
    endtask

    // Walk cycles c+1..c+6 of a single op and check busy, done and Sum
    task automatic runOp(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] exp_sum, input logic [15:0] old_sum);
        applyStimulus(a, b);
        for (int i = 1; i <= 6; i++) begin
            if (i > 1) @(negedge clk);
            checkOutput($sformatf("op busy c+%0d", i), {15'd0, busy}, (i <= 4) ? 16'd1 : 16'd0);
            checkOutput($sformatf("op done c+%0d", i), {15'd0, done}, (i == 5) ? 16'd1 : 16'd0);
            checkOutput($sformatf("op Sum c+%0d", i), sum, (i >= 5) ? exp_sum : old_sum);
        end
    endtask

    initial begin
        logic [15:0] last_sum;
        vec_count = 0;
        err_count = 0;
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        in1   = 16'h0000;
        in2   = 16'h0000;

        vecs[0] = '{16'h0101, 16'h0101, 16'h0004};
        vecs[1] = '{16'hFFFF, 16'hFFFF, 16'hFFFC};
        vecs[2] = '{16'h8080, 16'h8080, 16'hFE00};
        vecs[3] = '{16'h0102, 16'h0304, 16'h000A};
        vecs[4] = '{16'h00FF, 16'hFF00, 16'h01FE};
        vecs[5] = '{16'h7F80, 16'h0101, 16'h0101};

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        checkOutput("reset busy", {15'd0, busy}, 16'd0);
        checkOutput("reset done", {15'd0, done}, 16'd0);
        checkOutput("reset Sum", sum, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle busy", {15'd0, busy}, 16'd0);

        // Table of isolated operations
        last_sum = 16'h0000;
        for (int v = 0; v < 6; v++) begin
            runOp(vecs[v].in1, vecs[v].in2, vecs[v].exp_sum, last_sum);
            last_sum = vecs[v].exp_sum;
        end

        // Back-to-back: start held high, operands change while busy
        @(negedge clk);
        start = 1'b1;
        in1   = 16'h0102;
        in2   = 16'h0304;
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) begin
                in1 = 16'h0000;
                in2 = 16'h0001;
            end
            if (i == 10) start = 1'b0;
            checkOutput($sformatf("b2b busy c+%0d", i), {15'd0, busy},
                        ((i >= 1 && i <= 4) || (i >= 6 && i <= 9)) ? 16'd1 : 16'd0);
            checkOutput($sformatf("b2b done c+%0d", i), {15'd0, done},
                        (i == 5 || i == 10) ? 16'd1 : 16'd0);
            checkOutput($sformatf("b2b Sum c+%0d", i), sum,
                        (i < 5) ? last_sum : ((i < 10) ? 16'h000A : 16'h0001));
        end

        // Reset in cycle c+2 abandons the op and clears Sum
        applyStimulus(16'h0505, 16'h0505);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 3; i <= 7; i++) begin
            checkOutput($sformatf("rst busy c+%0d", i), {15'd0, busy}, 16'd0);
            checkOutput($sformatf("rst done c+%0d", i), {15'd0, done}, 16'd0);
            checkOutput($sformatf("rst Sum c+%0d", i), sum, 16'h0000);
            @(negedge clk);
        end

`ifdef RED_SEQ_FLUSH_EN
        // Establish a known Sum, then flush in cycle c+3 of the next op
        runOp(16'h0101, 16'h0101, 16'h0004, 16'h0000);
        applyStimulus(16'hFFFF, 16'hFFFF);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        checkOutput("flush busy c+4", {15'd0, busy}, 16'd0);
        checkOutput("flush done c+4", {15'd0, done}, 16'd0);
        checkOutput("flush Sum c+4", sum, 16'h0004);
        // New start right after the flush completes normally
        start = 1'b1;
        in1   = 16'h8080;
        in2   = 16'h8080;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
            checkOutput($sformatf("post-flush busy c+%0d", i), {15'd0, busy}, (i <= 4) ? 16'd1 : 16'd0);
            checkOutput($sformatf("post-flush done c+%0d", i), {15'd0, done}, (i == 5) ? 16'd1 : 16'd0);
            checkOutput($sformatf("post-flush Sum c+%0d", i), sum, (i >= 5) ? 16'hFE00 : 16'h0004);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
